// File: rtl/capture_sequencer_if.sv
// Command, trigger and FIFO handshake bundle for capture_sequencer.
// The slave modport is the sequencer itself; master is the host/trigger/FIFO side.
interface capture_sequencer_if #(
    parameter int SEG_W  = 16,
    parameter int HOLD_W = 16,
    parameter int TMO_W  = 32
);
    logic              start_i;
    logic              abort_i;
    logic [SEG_W-1:0]  num_segments_i;
    logic [HOLD_W-1:0] holdoff_i;
    logic [TMO_W-1:0]  timeout_i;
    logic              wait_drain_i;
    logic              armed_i;
    logic              capture_go_i;
    logic              capture_done_i;
    logic              fifo_empty_i;
    logic              arm_o;
    logic              busy_o;
    logic              done_o;
    logic              timeout_o;
    logic [SEG_W-1:0]  seg_count_o;
    logic [2:0]        state_o;

    modport master (
        output start_i, abort_i, num_segments_i, holdoff_i, timeout_i, wait_drain_i,
        output armed_i, capture_go_i, capture_done_i, fifo_empty_i,
        input  arm_o, busy_o, done_o, timeout_o, seg_count_o, state_o
    );

    modport slave (
        input  start_i, abort_i, num_segments_i, holdoff_i, timeout_i, wait_drain_i,
        input  armed_i, capture_go_i, capture_done_i, fifo_empty_i,
        output arm_o, busy_o, done_o, timeout_o, seg_count_o, state_o
    );
endinterface

// File: rtl/capture_sequencer.sv
// Multi-segment acquisition controller: arms the trigger unit once per segment,
// waits for capture completion, optional FIFO drain and holdoff, with a watchdog.
module capture_sequencer #(
    parameter int SEG_W  = 16,
    parameter int HOLD_W = 16,
    parameter int TMO_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    capture_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_CAPTURE   = 3'd3,
        S_DRAIN     = 3'd4,
        S_HOLDOFF   = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [SEG_W-1:0]  SEG_ONE  = SEG_W'(1);
    localparam logic [SEG_W-1:0]  SEG_MAX  = '1;
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

    state_t            state_reg;
    logic [SEG_W-1:0]  seg_reg;
    logic [SEG_W-1:0]  nseg_cfg_reg;
    logic [HOLD_W-1:0] hold_cfg_reg;
    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [TMO_W-1:0]  tmo_cfg_reg;
    logic [TMO_W-1:0]  wdog_reg;
    logic              drain_cfg_reg;
    logic              arm_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              timeout_reg;

    logic [SEG_W-1:0]  seg_inc;
    logic [SEG_W-1:0]  seg_target;
    logic              watched;
    logic              wdog_expire;

    assign seg_inc     = (seg_reg == SEG_MAX) ? seg_reg : seg_reg + SEG_ONE;
    assign seg_target  = (nseg_cfg_reg == '0) ? SEG_ONE : nseg_cfg_reg;
    assign watched     = (state_reg == S_ARM) || (state_reg == S_WAIT_TRIG) ||
                         (state_reg == S_CAPTURE);
    // wdog_reg counts completed watched cycles, so expiry lands exactly timeout cycles after ARM entry
    assign wdog_expire = (tmo_cfg_reg != '0) && ((wdog_reg + TMO_ONE) == tmo_cfg_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            seg_reg       <= '0;
            nseg_cfg_reg  <= '0;
            hold_cfg_reg  <= '0;
            hold_cnt_reg  <= '0;
            tmo_cfg_reg   <= '0;
            wdog_reg      <= '0;
            drain_cfg_reg <= 1'b0;
            arm_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (watched) begin
                wdog_reg <= wdog_reg + TMO_ONE;
            end
            if (bus.abort_i) begin
                state_reg <= S_IDLE;
                arm_reg   <= 1'b0;
                busy_reg  <= 1'b0;
            end else if (watched && wdog_expire &&
                         !(state_reg == S_CAPTURE && bus.capture_done_i)) begin
                state_reg   <= S_DONE;
                arm_reg     <= 1'b0;
                busy_reg    <= 1'b0;
                done_reg    <= 1'b1;
                timeout_reg <= 1'b1;
            end else begin
                case (state_reg)
                    S_IDLE, S_DONE: begin
                        if (bus.start_i) begin
                            nseg_cfg_reg  <= bus.num_segments_i;
                            hold_cfg_reg  <= bus.holdoff_i;
                            tmo_cfg_reg   <= bus.timeout_i;
                            drain_cfg_reg <= bus.wait_drain_i;
                            seg_reg       <= '0;
                            timeout_reg   <= 1'b0;
                            wdog_reg      <= '0;
                            state_reg     <= S_ARM;
                            arm_reg       <= 1'b1;
                            busy_reg      <= 1'b1;
                        end
                    end
                    S_ARM: begin
                        if (bus.armed_i || bus.capture_go_i) begin
                            state_reg <= S_WAIT_TRIG;
                        end
                    end
                    S_WAIT_TRIG: begin
                        if (bus.capture_go_i) begin
                            state_reg <= S_CAPTURE;
                            arm_reg   <= 1'b0;
                        end
                    end
                    S_CAPTURE: begin
                        if (bus.capture_done_i) begin
                            seg_reg <= seg_inc;
                            if (seg_inc >= seg_target) begin
                                state_reg <= S_DONE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                            end else if (drain_cfg_reg) begin
                                state_reg <= S_DRAIN;
                            end else begin
                                state_reg    <= S_HOLDOFF;
                                hold_cnt_reg <= hold_cfg_reg;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (bus.fifo_empty_i) begin
                            state_reg    <= S_HOLDOFF;
                            hold_cnt_reg <= hold_cfg_reg;
                        end
                    end
                    S_HOLDOFF: begin
                        if (hold_cnt_reg == '0) begin
                            state_reg <= S_ARM;
                            arm_reg   <= 1'b1;
                            wdog_reg  <= '0;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg - HOLD_ONE;
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        arm_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.arm_o       = arm_reg;
    assign bus.busy_o      = busy_reg;
    assign bus.done_o      = done_reg;
    assign bus.timeout_o   = timeout_reg;
    assign bus.seg_count_o = seg_reg;
    assign bus.state_o     = state_reg;
endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: plays host, trigger unit and FIFO,
// and checks every observed cycle against the expected segment timeline.
module tb_capture_sequencer;
    localparam int SEG_W  = 16;
    localparam int HOLD_W = 16;
    localparam int TMO_W  = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    capture_sequencer_if #(.SEG_W(SEG_W), .HOLD_W(HOLD_W), .TMO_W(TMO_W)) bus ();

    capture_sequencer #(.SEG_W(SEG_W), .HOLD_W(HOLD_W), .TMO_W(TMO_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_time_limit: observed=still_running expected=finished");
        $fatal(1, "time limit reached");
    end

    // Outputs are sampled and inputs driven on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int arm, input int busy,
                           input int done, input int tmo, input int seg);
        chk({tag, ".state"},   64'(bus.state_o),     64'(st));
        chk({tag, ".arm"},     64'(bus.arm_o),       64'(arm));
        chk({tag, ".busy"},    64'(bus.busy_o),      64'(busy));
        chk({tag, ".done"},    64'(bus.done_o),      64'(done));
        chk({tag, ".timeout"}, 64'(bus.timeout_o),   64'(tmo));
        chk({tag, ".seg"},     64'(bus.seg_count_o), 64'(seg));
    endtask

    // Pulse start with a config, then scramble the config inputs: only the latched copy matters.
    task automatic start_seq(input int nseg, input int hold, input int tmo, input bit drain);
        bus.num_segments_i = SEG_W'(nseg);
        bus.holdoff_i      = HOLD_W'(hold);
        bus.timeout_i      = TMO_W'(tmo);
        bus.wait_drain_i   = drain;
        bus.start_i        = 1'b1;
        step();
        bus.start_i        = 1'b0;
        bus.num_segments_i = SEG_W'($urandom);
        bus.holdoff_i      = HOLD_W'($urandom);
        bus.timeout_i      = TMO_W'($urandom_range(1, 3));
        bus.wait_drain_i   = ~drain;
        chk_all("start", 1, 1, 1, 0, 0, 0);
    endtask

    // Entered at the falling edge where arm_o is first seen high for segment s.
    task automatic run_segment(input int s, input int eff, input int hold, input bit drain,
                               input int td, input int cd, input int dd, input bit poke,
                               input bit tmo_early);
        bus.armed_i = 1'b1;
        for (int k = 1; k < td; k++) begin
            step();
            chk("wait.state", 64'(bus.state_o), 64'(2));
            chk("wait.arm", 64'(bus.arm_o), 64'(1));
            chk("wait.seg", 64'(bus.seg_count_o), 64'(s));
            bus.start_i = poke && (k == 1);
            if (poke && k == 1) begin
                bus.num_segments_i = '1;
                bus.holdoff_i      = HOLD_W'(9);
            end
        end
        bus.start_i      = 1'b0;
        bus.capture_go_i = 1'b1;
        bus.fifo_empty_i = 1'b0;
        step();
        bus.capture_go_i = 1'b0;
        bus.armed_i      = 1'b0;
        chk("cap.entry_state", 64'(bus.state_o), 64'(3));
        chk("cap.entry_arm", 64'(bus.arm_o), 64'(0));
        chk("cap.entry_busy", 64'(bus.busy_o), 64'(1));
        for (int k = 1; k < cd; k++) begin
            step();
            if (tmo_early && k == cd - 1) begin
                chk_all("tmo.before_done", 6, 0, 0, 1, 1, s);
                $display("segment %0d watchdog expiry one cycle before capture_done", s);
                return;
            end
            chk("cap.state", 64'(bus.state_o), 64'(3));
        end
        bus.capture_done_i = 1'b1;
        step();
        bus.capture_done_i = 1'b0;
        chk("cap.seg", 64'(bus.seg_count_o), 64'(s + 1));
        if (s + 1 >= eff) begin
            chk_all("done.entry", 6, 0, 0, 1, 0, s + 1);
            repeat (3) begin
                step();
                chk("done.once", 64'(bus.done_o), 64'(0));
                chk("done.hold", 64'(bus.state_o), 64'(6));
            end
        end else begin
            if (drain) begin
                for (int i = 0; i < dd; i++) begin
                    chk("drain.state", 64'(bus.state_o), 64'(4));
                    chk("drain.arm", 64'(bus.arm_o), 64'(0));
                    if (i == dd - 1) bus.fifo_empty_i = 1'b1;
                    step();
                end
            end
            for (int i = 0; i <= hold; i++) begin
                chk("hold.state", 64'(bus.state_o), 64'(5));
                chk("hold.arm", 64'(bus.arm_o), 64'(0));
                chk("hold.busy", 64'(bus.busy_o), 64'(1));
                step();
            end
            chk("rearm.state", 64'(bus.state_o), 64'(1));
            chk("rearm.arm", 64'(bus.arm_o), 64'(1));
            chk("rearm.seg", 64'(bus.seg_count_o), 64'(s + 1));
        end
        $display("segment %0d/%0d trig=%0d cap=%0d hold=%0d drain=%0d(%0d) seg_count=%0d",
                 s + 1, eff, td, cd, hold, drain, dd, bus.seg_count_o);
    endtask

    task automatic run_sequence(input int nseg, input int hold, input int tmo, input bit drain,
                                input int dd, input int td_fix, input int cd_fix);
        int eff;
        eff = (nseg == 0) ? 1 : nseg;
        start_seq(nseg, hold, tmo, drain);
        for (int s = 0; s < eff; s++) begin
            int td;
            int cd;
            td = (td_fix != 0) ? td_fix : int'($urandom_range(4, 20));
            cd = (cd_fix != 0) ? cd_fix : int'($urandom_range(2, 50));
            run_segment(s, eff, hold, drain, td, cd, dd, s == 0, 1'b0);
        end
    endtask

    initial begin
        reset                = 1'b1;
        bus.start_i          = 1'b0;
        bus.abort_i          = 1'b0;
        bus.num_segments_i   = '0;
        bus.holdoff_i        = '0;
        bus.timeout_i        = '0;
        bus.wait_drain_i     = 1'b0;
        bus.armed_i          = 1'b0;
        bus.capture_go_i     = 1'b0;
        bus.capture_done_i   = 1'b0;
        bus.fifo_empty_i     = 1'b1;
        repeat (2) step();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        chk_all("idle", 0, 0, 0, 0, 0, 0);

        // Three segments, holdoff 4, fixed trigger/capture latency.
        run_sequence(3, 4, 0, 1'b0, 1, 20, 50);

        // num_segments 0 behaves as one segment.
        run_sequence(0, int'($urandom_range(0, 5)), 0, 1'b0, 1, 0, 0);

        // start together with abort in DONE: abort wins.
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        chk_all("abort_start", 0, 0, 0, 0, 0, 1);
        step();
        chk("abort_start.stay", 64'(bus.state_o), 64'(0));

        // Drain wait of 100 cycles between two segments.
        run_sequence(2, int'($urandom_range(0, 6)), 0, 1'b1, 100, 0, 0);

        // Watchdog of 30 cycles with no trigger.
        start_seq(3, 2, 30, 1'b0);
        bus.armed_i = 1'b1;
        for (int k = 2; k <= 30; k++) begin
            step();
            chk("tmo.wait_state", 64'(bus.state_o), 64'(2));
            chk("tmo.wait_arm", 64'(bus.arm_o), 64'(1));
            chk("tmo.wait_flag", 64'(bus.timeout_o), 64'(0));
        end
        step();
        chk_all("tmo.expire", 6, 0, 0, 1, 1, 0);
        bus.armed_i = 1'b0;
        step();
        chk("tmo.done_once", 64'(bus.done_o), 64'(0));
        chk("tmo.sticky", 64'(bus.timeout_o), 64'(1));
        $display("watchdog expiry after 30 cycles timeout_o=%0d", bus.timeout_o);

        // Next start clears timeout_o (checked inside start_seq).
        run_sequence(1, 1, 0, 1'b0, 1, 0, 0);

        // Expiry on the same edge as capture_done: the segment counts, no timeout.
        start_seq(1, 0, 14, 1'b0);
        run_segment(0, 1, 0, 1'b0, 6, 8, 1, 1'b0, 1'b0);
        // Expiry one edge earlier: timeout wins, nothing counted.
        start_seq(1, 0, 13, 1'b0);
        run_segment(0, 1, 0, 1'b0, 6, 8, 1, 1'b0, 1'b1);

        // Abort while waiting for the trigger of segment 2.
        start_seq(2, 3, 0, 1'b0);
        run_segment(0, 2, 3, 1'b0, 8, 10, 1, 1'b0, 1'b0);
        bus.armed_i = 1'b1;
        step();
        chk("abort.pre_state", 64'(bus.state_o), 64'(2));
        bus.abort_i = 1'b1;
        step();
        bus.abort_i = 1'b0;
        bus.armed_i = 1'b0;
        chk_all("abort", 0, 0, 0, 0, 0, 1);
        step();
        chk_all("abort.after", 0, 0, 0, 0, 0, 1);
        $display("abort in segment 2 seg_count=%0d", bus.seg_count_o);

        // Reset during CAPTURE, then a normal sequence.
        start_seq(2, 1, 0, 1'b0);
        bus.armed_i = 1'b1;
        repeat (3) step();
        bus.capture_go_i = 1'b1;
        step();
        bus.capture_go_i = 1'b0;
        bus.armed_i      = 1'b0;
        chk("rst.cap_state", 64'(bus.state_o), 64'(3));
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_all("reset.mid", 0, 0, 0, 0, 0, 0);
        step();
        chk_all("reset.idle", 0, 0, 0, 0, 0, 0);
        $display("reset during capture returned to idle");
        run_sequence(2, 1, 0, 1'b0, 1, 0, 0);

        // Randomized sequences.
        for (int r = 0; r < 4; r++) begin
            int n;
            int h;
            int dd;
            int t;
            bit d;
            n  = int'($urandom_range(1, 4));
            h  = int'($urandom_range(0, 6));
            dd = int'($urandom_range(1, 12));
            t  = ($urandom_range(0, 1) == 0) ? 0 : 500;
            d  = 1'($urandom_range(0, 1));
            run_sequence(n, h, t, d, dd, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
